// File: rtl/qspi0_pad_arbiter.sv
// Two-master arbiter for the shared qspi0 flash pads (cs, sck, dq[3:0]).
// Round-robin req/gnt ownership with an idle guard gap between owners.
module qspi0_pad_arbiter #(
  parameter int unsigned GUARD_CYC = 4,
  parameter int unsigned MAX_HOLD  = 4096,
  parameter logic        SCK_IDLE  = 1'b0
) (
  input  logic       hfextclk,
  input  logic       globalrst,
  input  logic       m0_req,
  output logic       m0_gnt,
  input  logic       m0_cs_n,
  input  logic       m0_sck,
  input  logic [3:0] m0_dq_o,
  input  logic [3:0] m0_dq_oe,
  input  logic       m1_req,
  output logic       m1_gnt,
  input  logic       m1_cs_n,
  input  logic       m1_sck,
  input  logic [3:0] m1_dq_o,
  input  logic [3:0] m1_dq_oe,
  output logic       pad_cs_n,
  output logic       pad_sck,
  output logic [3:0] pad_dq_o,
  output logic [3:0] pad_dq_oe,
  input  logic [3:0] pad_dq_i,
  output logic       busy,
  output logic       hold_viol
);

  localparam int unsigned GuardW = $clog2(GUARD_CYC + 1);
  localparam int unsigned HoldW  = 13;
  localparam logic [HoldW-1:0] HoldSat = '1;

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StGuard} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;  // 1: M1 owned last
  logic [GuardW-1:0] guard_cnt_q, guard_cnt_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic              hold_viol_q, hold_viol_d;
  logic              m0_gnt_q, m1_gnt_q;
  logic              other_waiting;

  // Read data is fanned out to both masters outside this block.
  logic unused_pad_dq_i;
  assign unused_pad_dq_i = ^pad_dq_i;

  always_ff @(posedge hfextclk or posedge globalrst) begin
    if (globalrst) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      guard_cnt_q <= '0;
      hold_cnt_q  <= '0;
      hold_viol_q <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      guard_cnt_q <= guard_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_viol_q <= hold_viol_d;
      m0_gnt_q    <= (state_d == StOwn0);
      m1_gnt_q    <= (state_d == StOwn1);
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    guard_cnt_d = guard_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && (!m1_req || last_q)) begin
          state_d = StOwn0;
        end else if (m1_req) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        // Owner keeps the bus until its chip select is back high.
        if (!m0_req && m0_cs_n) begin
          state_d     = StGuard;
          last_d      = 1'b0;
          guard_cnt_d = GuardW'(GUARD_CYC);
        end
      end
      StOwn1: begin
        if (!m1_req && m1_cs_n) begin
          state_d     = StGuard;
          last_d      = 1'b1;
          guard_cnt_d = GuardW'(GUARD_CYC);
        end
      end
      StGuard: begin
        if (guard_cnt_q != '0) begin
          guard_cnt_d = guard_cnt_q - GuardW'(1);
        end
        if (guard_cnt_q <= GuardW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign other_waiting = ((state_q == StOwn0) && m1_req) || ((state_q == StOwn1) && m0_req);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((state_q == StIdle) && (state_d != StIdle)) begin
      hold_cnt_d = '0;
    end else if (other_waiting && (hold_cnt_q != HoldSat)) begin
      hold_cnt_d = hold_cnt_q + HoldW'(1);
    end
    // Fires only on the increment that lands on the limit, so a stalled count cannot re-pulse.
    hold_viol_d = (32'(hold_cnt_d) == MAX_HOLD) && (hold_cnt_d != hold_cnt_q);
  end

  always_comb begin
    pad_cs_n  = 1'b1;
    pad_sck   = SCK_IDLE;
    pad_dq_o  = '0;
    pad_dq_oe = '0;
    unique case (state_q)
      StOwn0: begin
        pad_cs_n  = m0_cs_n;
        pad_sck   = m0_sck;
        pad_dq_o  = m0_dq_o;
        pad_dq_oe = m0_dq_oe;
      end
      StOwn1: begin
        pad_cs_n  = m1_cs_n;
        pad_sck   = m1_sck;
        pad_dq_o  = m1_dq_o;
        pad_dq_oe = m1_dq_oe;
      end
      default: ;
    endcase
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign busy      = (state_q != StIdle);
  assign hold_viol = hold_viol_q;

endmodule

// File: tb/tb_qspi0_pad_arbiter.sv
// Randomised bench for qspi0_pad_arbiter against a timeline model of ownership,
// guard windows and hold counting.
module tb_qspi0_pad_arbiter;

  localparam int GUARD = 4;
  localparam int MAXH  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, cs_n, sck;
  logic [1:0][3:0]  dqo, dqoe;
  logic [3:0]       pad_dq_i;
  wire  [1:0]       gnt;
  wire              pad_cs_n, pad_sck, busy, hold_viol;
  wire  [3:0]       pad_dq_o, pad_dq_oe;

  always #5 clk = ~clk;

  qspi0_pad_arbiter #(
    .GUARD_CYC(GUARD),
    .MAX_HOLD (MAXH),
    .SCK_IDLE (1'b0)
  ) dut (
    .hfextclk (clk),
    .globalrst(rst),
    .m0_req   (req[0]),
    .m0_gnt   (gnt[0]),
    .m0_cs_n  (cs_n[0]),
    .m0_sck   (sck[0]),
    .m0_dq_o  (dqo[0]),
    .m0_dq_oe (dqoe[0]),
    .m1_req   (req[1]),
    .m1_gnt   (gnt[1]),
    .m1_cs_n  (cs_n[1]),
    .m1_sck   (sck[1]),
    .m1_dq_o  (dqo[1]),
    .m1_dq_oe (dqoe[1]),
    .pad_cs_n (pad_cs_n),
    .pad_sck  (pad_sck),
    .pad_dq_o (pad_dq_o),
    .pad_dq_oe(pad_dq_oe),
    .pad_dq_i (pad_dq_i),
    .busy     (busy),
    .hold_viol(hold_viol)
  );

  wire [13:0] obs = {gnt[0], gnt[1], pad_cs_n, pad_sck, pad_dq_o, pad_dq_oe, busy, hold_viol};
  localparam logic [13:0] IdleVec = {2'b00, 1'b1, 1'b0, 8'h00, 2'b00};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, when arbitration may next happen.
  int m_owner, m_last, m_free_at, m_held, cyc;
  bit m_viol;
  int order_q[$];

  function automatic void model_reset();
    m_owner   = -1;
    m_last    = 1;
    m_free_at = 0;
    m_held    = 0;
    m_viol    = 1'b0;
  endfunction

  function automatic void model_step();
    int o;
    m_viol = 1'b0;
    if (m_owner >= 0) begin
      o = 1 - m_owner;
      if (req[o]) begin
        m_held++;
        if (m_held == MAXH) m_viol = 1'b1;
      end
      if (!req[m_owner] && cs_n[m_owner]) begin
        m_last    = m_owner;
        m_owner   = -1;
        m_free_at = cyc + 1 + GUARD;
      end
    end else if (cyc >= m_free_at && req != 2'b00) begin
      m_owner = (req == 2'b11) ? 1 - m_last : (req[0] ? 0 : 1);
      m_held  = 0;
      order_q.push_back(m_owner);
    end
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [9:0] p;
    p = {1'b1, 1'b0, 4'h0, 4'h0};
    if (m_owner == 0)      p = {cs_n[0], sck[0], dqo[0], dqoe[0]};
    else if (m_owner == 1) p = {cs_n[1], sck[1], dqo[1], dqoe[1]};
    return {m_owner == 0, m_owner == 1, p, (m_owner >= 0) || (cyc < m_free_at), m_viol};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    cyc++;
    #1;
  endtask

  task automatic scramble(input int m);
    sck[m]  = 1'($urandom);
    dqo[m]  = 4'($urandom);
    dqoe[m] = 4'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; cs_n = 2'b11;
    scramble(0); scramble(1);
    tick();
    n_checks++;
    if (obs !== IdleVec) begin
      n_fail++; $display("FAIL reset_idle obs=%b exp=%b", obs, IdleVec);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL reset_tie_m0 gnt=%b exp=01", gnt);
    end
    req[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cs_n[0] = 1'b0; scramble(0); scramble(1);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL reset_xact obs=%b exp=%b", obs, exp_vec());
      end
    end
    cs_n[0] = 1'b1; req[0] = 1'b0;
    for (int i = 0; i < GUARD + 2; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL reset_release obs=%b exp=%b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_m1_read();
    int gnt_at;
    req = 2'b10;
    cs_n[0] = 1'b0;  // M0 misbehaves without a grant; pads must ignore it
    tick();
    for (int b = 0; b < 18; b++) begin
      cs_n[1] = 1'b0; scramble(1); scramble(0);
      sck[1]  = b[0];
      if (b >= 2) dqoe[1] = 4'h0;
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL m1_mirror obs=%b exp=%b", obs, exp_vec());
      end
    end
    cs_n = 2'b11; req = 2'b01;
    gnt_at = -1;
    for (int i = 1; i <= 12 && gnt_at < 0; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL m1_guard obs=%b exp=%b", obs, exp_vec());
      end
      if (i <= GUARD) begin
        n_checks++;
        if (pad_cs_n !== 1'b1 || pad_dq_oe !== 4'h0) begin
          n_fail++; $display("FAIL guard_pads cs=%b oe=%h exp cs=1 oe=0", pad_cs_n, pad_dq_oe);
        end
      end
      if (gnt[0] === 1'b1) gnt_at = i;
    end
    n_checks++;
    if (gnt_at != GUARD + 2) begin
      n_fail++; $display("FAIL release_to_gnt got=%0d exp=%0d", gnt_at, GUARD + 2);
    end
    cs_n[0] = 1'b0; scramble(0);
    tick();
    cs_n[0] = 1'b1; req[0] = 1'b0;
    for (int i = 0; i < GUARD + 2; i++) tick();
  endtask

  task automatic test_req_drop();
    req = 2'b01;
    tick();
    for (int i = 0; i < 2; i++) begin
      cs_n[0] = 1'b0; scramble(0);
      tick();
    end
    req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      scramble(0);
      tick();
      n_checks++;
      if (gnt[0] !== 1'b1 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL drop_hold gnt0=%b obs=%b exp=%b", gnt[0], obs, exp_vec());
      end
    end
    cs_n[0] = 1'b1;
    #1;
    n_checks++;
    if (pad_cs_n !== 1'b1) begin
      n_fail++; $display("FAIL drop_cs_rise cs=%b exp=1", pad_cs_n);
    end
    for (int i = 0; i < GUARD + 1; i++) begin
      tick();
      n_checks++;
      if (pad_cs_n !== 1'b1 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL drop_guard obs=%b exp=%b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_alternate();
    int left[2];
    int beats[2];
    int budget;
    int first_exp;
    bit done;
    order_q.delete();
    first_exp = 1 - m_last;
    left = '{5, 5};
    req = 2'b11; cs_n = 2'b11;
    beats[0] = $urandom_range(2, 6);
    beats[1] = $urandom_range(2, 6);
    budget = 0; done = 1'b0;
    while (!done && budget < 2000) begin
      tick();
      budget++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL alt_cycle obs=%b exp=%b", obs, exp_vec());
      end
      n_checks++;
      if (gnt === 2'b11) begin
        n_fail++; $display("FAIL alt_both_gnt gnt=%b", gnt);
      end
      for (int m = 0; m < 2; m++) begin
        if (gnt[m]) begin
          if (beats[m] > 0) begin
            cs_n[m] = 1'b0; scramble(m); beats[m]--;
          end else if (req[m]) begin
            cs_n[m] = 1'b1; req[m] = 1'b0; left[m]--;
          end
        end else begin
          scramble(m);
          if (!req[m] && left[m] > 0) begin
            req[m] = 1'b1; beats[m] = $urandom_range(2, 6);
          end
        end
      end
      if (left[0] == 0 && left[1] == 0 && m_owner < 0 && cyc >= m_free_at) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL alt_timeout cycles=%0d", budget);
    end
    n_checks++;
    if (order_q.size() != 10) begin
      n_fail++; $display("FAIL alt_count got=%0d exp=10", order_q.size());
    end
    for (int i = 0; i < order_q.size(); i++) begin
      n_checks++;
      if (order_q[i] != ((first_exp + i) % 2)) begin
        n_fail++; $display("FAIL alt_order idx=%0d got=M%0d exp=M%0d", i, order_q[i],
                           (first_exp + i) % 2);
      end
    end
  endtask

  task automatic test_hold();
    int pulses, pulse_at;
    req = 2'b01; cs_n = 2'b11;
    tick();
    cs_n[0] = 1'b0;
    req[1]  = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 40; i++) begin
      scramble(0); scramble(1);
      tick();
      n_checks++;
      if (gnt[0] !== 1'b1 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL hold_cycle i=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
      if (hold_viol === 1'b1) begin
        pulses++; pulse_at = i;
      end
    end
    n_checks++;
    if (pulses != 1 || pulse_at != MAXH) begin
      n_fail++; $display("FAIL hold_pulse count=%0d at=%0d exp count=1 at=%0d", pulses, pulse_at,
                         MAXH);
    end
    cs_n = 2'b11; req = 2'b00;
    for (int i = 0; i < GUARD + 2; i++) tick();
  endtask

  task automatic test_reset_mid();
    req = 2'b10;
    tick();
    for (int i = 0; i < 3; i++) begin
      cs_n[1] = 1'b0; scramble(1); dqoe[1] = 4'hF;
      tick();
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs !== IdleVec || obs !== exp_vec()) begin
      n_fail++; $display("FAIL midreset_pads obs=%b exp=%b", obs, IdleVec);
    end
    tick();
    tick();
    rst = 1'b0; req = 2'b01; cs_n = 2'b11;
    tick();
    n_checks++;
    if (gnt !== 2'b01 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL midreset_regrant gnt=%b exp=01", gnt);
    end
    req = 2'b00;
    for (int i = 0; i < GUARD + 2; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL midreset_tail obs=%b exp=%b", obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; cs_n = 2'b11; sck = 2'b00;
    dqo = '0; dqoe = '0; pad_dq_i = 4'h0; cyc = 0;
    model_reset();
    test_reset();
    test_m1_read();
    test_req_drop();
    test_alternate();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
